l2_cache_2way: RTL and testbench

Parametrised two-channel, 2-way set-associative, write-back L2 cache placed between the L1 instruction/data caches and the two slow-memory ports. Each channel (i, d) owns a private partition of 2^IDX_W sets, has its own FSM and memory port, and runs fully independently of the other channel. Replacement is LRU, and full-line write misses install without a memory fetch. Per-channel saturating hit/miss counters support performance bring-up.

---
 rtl/l2_cache_2way_if.sv | 31 +++
 rtl/l2_cache_2way.sv | 208 ++++++++++++++++++++
 tb/tb_l2_cache_2way.sv | 397 +++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/l2_cache_2way_if.sv
// One L2 channel's bus bundle: the L1-side request/response pair and the
// slow-memory port behind it. The cache holds the slave view; the requester
// and memory model hold the master view.
interface l2_cache_2way_if #(
  parameter int ADDR_W = 28,
  parameter int LINE_W = 128
);
  logic              l1_read;
  logic              l1_write;
  logic [ADDR_W-1:0] l1_addr;
  logic [LINE_W-1:0] l1_wdata;
  logic [LINE_W-1:0] l1_rdata;
  logic              l1_ready;

  logic              mem_read;
  logic              mem_write;
  logic [ADDR_W-1:0] mem_addr;
  logic [LINE_W-1:0] mem_wdata;
  logic [LINE_W-1:0] mem_rdata;
  logic              mem_ready;

  modport slave (
    input  l1_read, l1_write, l1_addr, l1_wdata, mem_rdata, mem_ready,
    output l1_rdata, l1_ready, mem_read, mem_write, mem_addr, mem_wdata
  );

  modport master (
    output l1_read, l1_write, l1_addr, l1_wdata, mem_rdata, mem_ready,
    input  l1_rdata, l1_ready, mem_read, mem_write, mem_addr, mem_wdata
  );
endinterface

// File: rtl/l2_cache_2way.sv
// Two-channel 2-way set-associative write-back L2 cache. Each channel (i, d)
// is an independent l2_cache_channel with its own sets, FSM and memory port.
// Replacement is LRU; full-line write misses install without a fetch.

module l2_cache_channel #(
  parameter int ADDR_W = 28,
  parameter int LINE_W = 128,
  parameter int IDX_W  = 5,
  parameter int CNT_W  = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  l2_cache_2way_if.slave   bus,
  output logic [CNT_W-1:0] hit_cnt,
  output logic [CNT_W-1:0] miss_cnt
);
  localparam int TAG_W = ADDR_W - IDX_W;
  localparam int SETS  = 1 << IDX_W;

  typedef enum logic [1:0] {IDLE, WRITE_BACK, ALLOCATE, RESP} state_t;

  state_t            state;
  logic [SETS-1:0]   valid [2];
  logic [SETS-1:0]   dirty [2];
  logic [SETS-1:0]   lru;          // way to evict next in each set
  logic [TAG_W-1:0]  tag_mem  [2][SETS];
  logic [LINE_W-1:0] data_mem [2][SETS];
  logic              victim_q;     // victim way chosen at the IDLE decision

  logic [IDX_W-1:0]  idx;
  logic [TAG_W-1:0]  tag;
  logic              req, is_wr;
  logic              hit0, hit1, hit, hit_way;
  logic              victim, victim_dirty;

  assign idx   = bus.l1_addr[IDX_W-1:0];
  assign tag   = bus.l1_addr[ADDR_W-1:IDX_W];
  assign req   = bus.l1_read | bus.l1_write;
  assign is_wr = bus.l1_write;  // read+write together is a write

  assign hit0    = valid[0][idx] && (tag_mem[0][idx] == tag);
  assign hit1    = valid[1][idx] && (tag_mem[1][idx] == tag);
  assign hit     = hit0 | hit1;
  assign hit_way = !hit0;

  // Victim: first invalid way (way0 first), otherwise the LRU way.
  always_comb begin
    if (!valid[0][idx])      victim = 1'b0;
    else if (!valid[1][idx]) victim = 1'b1;
    else                     victim = lru[idx];
    victim_dirty = valid[victim][idx] && dirty[victim][idx];
  end

  logic              inst_en;
  logic              inst_way;
  logic [LINE_W-1:0] inst_data;

  // Select when and what to write into the tag/data arrays.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    inst_en   = 1'b0;
    inst_way  = victim_q;
    inst_data = bus.l1_wdata;
    case (state)
      IDLE: if (req && is_wr) begin
        if (hit) begin
          inst_en  = 1'b1;
          inst_way = hit_way;
        end else if (!victim_dirty) begin
          inst_en  = 1'b1;
          inst_way = victim;
        end
      end
      WRITE_BACK: inst_en = bus.mem_ready && is_wr;
      ALLOCATE: if (bus.mem_ready) begin
        inst_en   = 1'b1;
        inst_data = bus.mem_rdata;
      end
      default: ;
    endcase
  end

  // Tag/data arrays; meaningless until the matching valid bit is set.
  // NOTE: storage arrays carry no reset; only the valid/dirty/LRU state that guards them is reset.
  always_ff @(posedge clk) begin
    if (inst_en) begin
      tag_mem[inst_way][idx]  <= tag;
      data_mem[inst_way][idx] <= inst_data;
    end
  end

  // Channel FSM with registered L1/memory outputs, line state and counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      valid[0]      <= '0;
      valid[1]      <= '0;
      dirty[0]      <= '0;
      dirty[1]      <= '0;
      lru           <= '0;
      victim_q      <= 1'b0;
      bus.l1_rdata  <= '0;
      bus.l1_ready  <= 1'b0;
      bus.mem_read  <= 1'b0;
      bus.mem_write <= 1'b0;
      bus.mem_addr  <= '0;
      bus.mem_wdata <= '0;
      hit_cnt       <= '0;
      miss_cnt      <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every read sees pre-edge values.
      case (state)
        IDLE: if (req) begin
          if (hit) begin
            if (hit_cnt != '1) hit_cnt <= hit_cnt + CNT_W'(1);
            lru[idx] <= ~hit_way;
            if (is_wr) dirty[hit_way][idx] <= 1'b1;
            else       bus.l1_rdata <= data_mem[hit_way][idx];
            bus.l1_ready <= 1'b1;
            state        <= RESP;
          end else begin
            if (miss_cnt != '1) miss_cnt <= miss_cnt + CNT_W'(1);
            victim_q <= victim;
            if (victim_dirty) begin
              bus.mem_write <= 1'b1;
              bus.mem_addr  <= {tag_mem[victim][idx], idx};
              bus.mem_wdata <= data_mem[victim][idx];
              state         <= WRITE_BACK;
            end else if (is_wr) begin
              valid[victim][idx] <= 1'b1;
              dirty[victim][idx] <= 1'b1;
              lru[idx]           <= ~victim;
              bus.l1_ready       <= 1'b1;
              state              <= RESP;
            end else begin
              bus.mem_read <= 1'b1;
              bus.mem_addr <= bus.l1_addr;
              state        <= ALLOCATE;
            end
          end
        end
        WRITE_BACK: if (bus.mem_ready) begin
          bus.mem_write <= 1'b0;
          bus.mem_wdata <= '0;
          if (is_wr) begin
            valid[victim_q][idx] <= 1'b1;
            dirty[victim_q][idx] <= 1'b1;
            lru[idx]             <= ~victim_q;
            bus.mem_addr         <= '0;
            bus.l1_ready         <= 1'b1;
            state                <= RESP;
          end else begin
            bus.mem_read <= 1'b1;
            bus.mem_addr <= bus.l1_addr;
            state        <= ALLOCATE;
          end
        end
        ALLOCATE: if (bus.mem_ready) begin
          bus.mem_read         <= 1'b0;
          bus.mem_addr         <= '0;
          valid[victim_q][idx] <= 1'b1;
          dirty[victim_q][idx] <= 1'b0;
          lru[idx]             <= ~victim_q;
          bus.l1_rdata         <= bus.mem_rdata;
          bus.l1_ready         <= 1'b1;
          state                <= RESP;
        end
        RESP: begin
          bus.l1_ready <= 1'b0;
          state        <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

module l2_cache_2way #(
  parameter int ADDR_W = 28,
  parameter int LINE_W = 128,
  parameter int IDX_W  = 5,
  parameter int CNT_W  = 32
) (
  input  logic             clk,
  input  logic             proc_reset_n,
  l2_cache_2way_if.slave   i_bus,
  l2_cache_2way_if.slave   d_bus,
  output logic [CNT_W-1:0] i_hit_cnt,
  output logic [CNT_W-1:0] i_miss_cnt,
  output logic [CNT_W-1:0] d_hit_cnt,
  output logic [CNT_W-1:0] d_miss_cnt
);
  l2_cache_channel #(.ADDR_W(ADDR_W), .LINE_W(LINE_W), .IDX_W(IDX_W), .CNT_W(CNT_W)) u_i_chan (
    .clk      (clk),
    .rst_n    (proc_reset_n),
    .bus      (i_bus),
    .hit_cnt  (i_hit_cnt),
    .miss_cnt (i_miss_cnt)
  );

  l2_cache_channel #(.ADDR_W(ADDR_W), .LINE_W(LINE_W), .IDX_W(IDX_W), .CNT_W(CNT_W)) u_d_chan (
    .clk      (clk),
    .rst_n    (proc_reset_n),
    .bus      (d_bus),
    .hit_cnt  (d_hit_cnt),
    .miss_cnt (d_miss_cnt)
  );
endmodule

// File: tb/tb_l2_cache_2way.sv
// Self-checking bench for l2_cache_2way. The reference model keeps each set as
// a recency-ordered list of at most two lines plus a backing memory; every
// transaction's hit/miss, write-back, fill, read data, latency and counters are
// predicted from that model. Channel 2 is a second instance with CNT_W=2.
module tb_l2_cache_2way;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  l2_cache_2way_if ibus ();
  l2_cache_2way_if dbus ();
  l2_cache_2way_if sbus ();
  l2_cache_2way_if sdbus ();

  logic [31:0] i_hit, i_miss, d_hit, d_miss;
  logic [1:0]  s_hit, s_miss, sd_hit, sd_miss;

  l2_cache_2way dut (
    .clk(clk), .proc_reset_n(rst_n), .i_bus(ibus), .d_bus(dbus),
    .i_hit_cnt(i_hit), .i_miss_cnt(i_miss), .d_hit_cnt(d_hit), .d_miss_cnt(d_miss)
  );

  l2_cache_2way #(.CNT_W(2)) dut_sat (
    .clk(clk), .proc_reset_n(rst_n), .i_bus(sbus), .d_bus(sdbus),
    .i_hit_cnt(s_hit), .i_miss_cnt(s_miss), .d_hit_cnt(sd_hit), .d_miss_cnt(sd_miss)
  );

  int checks = 0;
  int failures = 0;

  typedef struct packed {
    logic [22:0]  tag;
    logic [127:0] data;
    logic         dirty;
  } line_t;

  typedef struct packed {
    logic         ready;
    logic [127:0] rdata;
    logic         mr;
    logic         mw;
    logic [27:0]  maddr;
    logic [127:0] mwdata;
    logic [31:0]  hc;
    logic [31:0]  mc;
  } obs_t;

  // Model: index 0 of each set is the most recently used line.
  line_t        mline [3][32][2];
  int           mcnt  [3][32];
  int unsigned  mhit  [3];
  int unsigned  mmiss [3];
  logic [127:0] refmem [logic [29:0]];
  time          fill_time [3];

  function automatic int unsigned cmax(input int ch);
    return (ch == 2) ? 32'd3 : 32'hFFFF_FFFF;
  endfunction

  function automatic logic [29:0] mkey(input int ch, input logic [27:0] a);
    logic [1:0] c2;
    c2 = ch[1:0];
    return {c2, a};
  endfunction

  function automatic logic [127:0] fetch(input int ch, input logic [27:0] a);
    logic [29:0] k;
    k = mkey(ch, a);
    if (!refmem.exists(k)) refmem[k] = {$urandom, $urandom, $urandom, $urandom};
    return refmem[k];
  endfunction

  task automatic reset_model();
    for (int c = 0; c < 3; c++) begin
      mhit[c] = 0;
      mmiss[c] = 0;
      for (int s = 0; s < 32; s++) mcnt[c][s] = 0;
    end
  endtask

  task automatic model_access(input int ch, input bit wr, input logic [27:0] a,
                              input logic [127:0] wd, output bit hit, output bit wb,
                              output logic [27:0] wb_a, output logic [127:0] wb_d,
                              output bit fill, output logic [127:0] rd);
    int          idx;
    int          k;
    logic [22:0] tg;
    line_t       ln;
    line_t       old;
    idx = int'(a[4:0]);
    tg  = a[27:5];
    k   = -1;
    hit = 0; wb = 0; wb_a = '0; wb_d = '0; fill = 0; rd = '0;
    for (int j = 0; j < mcnt[ch][idx]; j++) if (mline[ch][idx][j].tag == tg) k = j;
    if (k >= 0) begin
      hit = 1;
      ln  = mline[ch][idx][k];
      if (wr) begin ln.data = wd; ln.dirty = 1'b1; end
      else rd = ln.data;
      if (mhit[ch] != cmax(ch)) mhit[ch]++;
    end else begin
      if (mmiss[ch] != cmax(ch)) mmiss[ch]++;
      if (mcnt[ch][idx] == 2) begin
        old = mline[ch][idx][1];
        if (old.dirty) begin
          wb   = 1;
          wb_a = {old.tag, a[4:0]};
          wb_d = old.data;
          refmem[mkey(ch, wb_a)] = wb_d;
        end
        k = 1;
      end else begin
        k = mcnt[ch][idx];
        mcnt[ch][idx]++;
      end
      ln.tag = tg;
      if (wr) begin
        ln.data = wd; ln.dirty = 1'b1;
      end else begin
        fill = 1;
        rd = fetch(ch, a);
        ln.data = rd; ln.dirty = 1'b0;
      end
    end
    for (int j = k; j > 0; j--) mline[ch][idx][j] = mline[ch][idx][j-1];
    mline[ch][idx][0] = ln;
  endtask

  function automatic obs_t sample(input int ch);
    obs_t o;
    case (ch)
      0: o = {ibus.l1_ready, ibus.l1_rdata, ibus.mem_read, ibus.mem_write,
              ibus.mem_addr, ibus.mem_wdata, i_hit, i_miss};
      1: o = {dbus.l1_ready, dbus.l1_rdata, dbus.mem_read, dbus.mem_write,
              dbus.mem_addr, dbus.mem_wdata, d_hit, d_miss};
      default: o = {sbus.l1_ready, sbus.l1_rdata, sbus.mem_read, sbus.mem_write,
                    sbus.mem_addr, sbus.mem_wdata, 30'd0, s_hit, 30'd0, s_miss};
    endcase
    return o;
  endfunction

  task automatic drive_req(input int ch, input logic rd, input logic wr,
                           input logic [27:0] a, input logic [127:0] wd);
    case (ch)
      0: begin ibus.l1_read = rd; ibus.l1_write = wr; ibus.l1_addr = a; ibus.l1_wdata = wd; end
      1: begin dbus.l1_read = rd; dbus.l1_write = wr; dbus.l1_addr = a; dbus.l1_wdata = wd; end
      default: begin sbus.l1_read = rd; sbus.l1_write = wr; sbus.l1_addr = a; sbus.l1_wdata = wd; end
    endcase
  endtask

  task automatic drive_mem(input int ch, input logic rdy, input logic [127:0] d);
    case (ch)
      0: begin ibus.mem_ready = rdy; ibus.mem_rdata = d; end
      1: begin dbus.mem_ready = rdy; dbus.mem_rdata = d; end
      default: begin sbus.mem_ready = rdy; sbus.mem_rdata = d; end
    endcase
  endtask

  // One L1 request with a memory responder of latency lat, checked end to end.
  task automatic txn(input int ch, input logic rd, input logic wr, input logic [27:0] a,
                     input logic [127:0] wd, input int lat);
    bit           is_wr, hit, wb, fill, done;
    logic [27:0]  wb_a;
    logic [127:0] wb_d, exp_rd;
    int           cyc, wb_n, rd_n, exp_cyc;
    obs_t         o;
    is_wr = wr;
    cyc = 0; wb_n = 0; rd_n = 0; done = 0;
    model_access(ch, is_wr, a, wd, hit, wb, wb_a, wb_d, fill, exp_rd);
    exp_cyc = 1 + (wb ? lat : 0) + (fill ? lat : 0);
    @(negedge clk);
    drive_req(ch, rd, wr, a, wd);
    while (!done) begin
      @(negedge clk);
      cyc++;
      drive_mem(ch, 1'b0, '0);
      o = sample(ch);
      if (o.ready) begin
        done = 1;
        checks++;
        if (cyc !== exp_cyc) begin
          failures++;
          $display("FAIL latency ch%0d addr %h: ready at cycle %0d, expected %0d", ch, a, cyc, exp_cyc);
        end
        if (!is_wr) begin
          checks++;
          if (o.rdata !== exp_rd) begin
            failures++;
            $display("FAIL rdata ch%0d addr %h: got %h expected %h", ch, a, o.rdata, exp_rd);
          end
        end
        checks++;
        if (o.mr !== 1'b0 || o.mw !== 1'b0 || o.maddr !== '0 || o.mwdata !== '0) begin
          failures++;
          $display("FAIL mem_idle ch%0d: read=%b write=%b addr=%h during ready", ch, o.mr, o.mw, o.maddr);
        end
        checks++;
        if (wb_n !== (wb ? lat : 0) || rd_n !== (fill ? lat : 0)) begin
          failures++;
          $display("FAIL mem_traffic ch%0d addr %h: wb cycles %0d fill cycles %0d, expected %0d %0d",
                   ch, a, wb_n, rd_n, wb ? lat : 0, fill ? lat : 0);
        end
      end else if (o.mw) begin
        wb_n++;
        if (wb_n == 1) begin
          checks++;
          if (!wb || o.mr || o.maddr !== wb_a || o.mwdata !== wb_d) begin
            failures++;
            $display("FAIL write_back ch%0d: got addr %h data %h, expected wb=%0b addr %h data %h",
                     ch, o.maddr, o.mwdata, wb, wb_a, wb_d);
          end
        end
        if (wb_n == lat) drive_mem(ch, 1'b1, '0);
      end else if (o.mr) begin
        rd_n++;
        if (rd_n == 1) begin
          fill_time[ch] = $time;
          checks++;
          if (!fill || o.maddr !== a || wb_n !== (wb ? lat : 0)) begin
            failures++;
            $display("FAIL fill ch%0d: got addr %h after %0d wb cycles, expected fill=%0b addr %h",
                     ch, o.maddr, wb_n, fill, a);
          end
        end
        if (rd_n == lat) drive_mem(ch, 1'b1, exp_rd);
      end
      if (!done && cyc >= 100) begin
        failures++;
        $display("FAIL timeout ch%0d addr %h: no ready within 100 cycles", ch, a);
        done = 1;
      end
    end
    drive_req(ch, 1'b0, 1'b0, '0, '0);
    drive_mem(ch, 1'b0, '0);
    @(negedge clk);
    o = sample(ch);
    checks++;
    if (o.ready !== 1'b0) begin
      failures++;
      $display("FAIL ready_pulse ch%0d: ready still %b one cycle later, expected 0", ch, o.ready);
    end
    checks++;
    if (o.hc !== mhit[ch] || o.mc !== mmiss[ch]) begin
      failures++;
      $display("FAIL counters ch%0d: hit=%0d miss=%0d expected hit=%0d miss=%0d",
               ch, o.hc, o.mc, mhit[ch], mmiss[ch]);
    end
  endtask

  task automatic test_reset();
    obs_t o;
    rst_n = 1'b0;
    for (int c = 0; c < 3; c++) begin
      drive_req(c, 1'b0, 1'b0, '0, '0);
      drive_mem(c, 1'b0, '0);
    end
    sdbus.l1_read = 1'b0; sdbus.l1_write = 1'b0; sdbus.l1_addr = '0; sdbus.l1_wdata = '0;
    sdbus.mem_ready = 1'b0; sdbus.mem_rdata = '0;
    reset_model();
    #3;
    for (int c = 0; c < 3; c++) begin
      o = sample(c);
      checks++;
      if (o !== '0) begin
        failures++;
        $display("FAIL reset_state ch%0d: ready=%b rdata=%h mr=%b mw=%b hit=%0d miss=%0d, expected all 0",
                 c, o.ready, o.rdata, o.mr, o.mw, o.hc, o.mc);
      end
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_read_miss_hit();
    obs_t o;
    refmem[mkey(0, 28'h0000021)] = {16{8'hA5}};
    txn(0, 1'b1, 1'b0, 28'h0000021, '0, 3);
    txn(0, 1'b1, 1'b0, 28'h0000021, '0, 3);
    o = sample(0);
    checks++;
    if (o.hc !== 32'd1 || o.mc !== 32'd1 || o.rdata !== {16{8'hA5}}) begin
      failures++;
      $display("FAIL read_hit_count: hit=%0d miss=%0d rdata=%h, expected 1 1 a5..", o.hc, o.mc, o.rdata);
    end
  endtask

  task automatic test_write_evict();
    txn(1, 1'b0, 1'b1, 28'h0000003, {16{8'h11}}, 2);
    txn(1, 1'b1, 1'b0, 28'h0000023, '0, 2);
    txn(1, 1'b1, 1'b0, 28'h0000003, '0, 2);
    txn(1, 1'b1, 1'b0, 28'h0000043, '0, 2);
    txn(1, 1'b1, 1'b0, 28'h0000063, '0, 3);
  endtask

  task automatic test_concurrent();
    fill_time[0] = 0;
    fill_time[1] = 0;
    fork
      txn(0, 1'b1, 1'b0, 28'h0000101, '0, 2);
      txn(1, 1'b1, 1'b0, 28'h0000104, '0, 5);
    join
    checks++;
    if (fill_time[0] == 0 || fill_time[0] !== fill_time[1]) begin
      failures++;
      $display("FAIL concurrent_fill: memi_read first at %0t, memd_read first at %0t, expected equal",
               fill_time[0], fill_time[1]);
    end
  endtask

  task automatic test_reset_mid_alloc();
    obs_t o;
    @(negedge clk);
    drive_req(0, 1'b1, 1'b0, 28'h0000155, '0);
    @(negedge clk);
    o = sample(0);
    checks++;
    if (o.mr !== 1'b1) begin
      failures++;
      $display("FAIL alloc_entry: memi_read=%b, expected 1", o.mr);
    end
    #2 rst_n = 1'b0;
    #1 o = sample(0);
    checks++;
    if (o.mr !== 1'b0 || o.maddr !== '0 || o.ready !== 1'b0 || o.hc !== '0 || o.mc !== '0) begin
      failures++;
      $display("FAIL async_reset: mr=%b addr=%h ready=%b hit=%0d miss=%0d, expected all 0",
               o.mr, o.maddr, o.ready, o.hc, o.mc);
    end
    @(negedge clk);
    drive_req(0, 1'b0, 1'b0, '0, '0);
    @(negedge clk);
    rst_n = 1'b1;
    reset_model();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      o = sample(0);
      checks++;
      if (o.ready !== 1'b0 || o.mr !== 1'b0) begin
        failures++;
        $display("FAIL no_pulse_after_reset: ready=%b mr=%b, expected 0 0", o.ready, o.mr);
      end
    end
    txn(0, 1'b1, 1'b0, 28'h0000155, '0, 2);
  endtask

  task automatic test_rw_both();
    txn(1, 1'b1, 1'b0, 28'h0000007, '0, 1);
    txn(1, 1'b1, 1'b1, 28'h0000007, {16{8'h22}}, 1);
    txn(1, 1'b1, 1'b0, 28'h0000007, '0, 1);
    txn(1, 1'b1, 1'b0, 28'h0000027, '0, 1);
    txn(1, 1'b1, 1'b0, 28'h0000047, '0, 2);
  endtask

  task automatic test_saturation();
    obs_t o;
    txn(2, 1'b1, 1'b0, 28'h0000001, '0, 1);
    for (int i = 0; i < 5; i++) txn(2, 1'b1, 1'b0, 28'h0000001, '0, 1);
    o = sample(2);
    checks++;
    if (o.hc !== 32'd3 || o.mc !== 32'd1) begin
      failures++;
      $display("FAIL saturation: hit=%0d miss=%0d, expected 3 1", o.hc, o.mc);
    end
  endtask

  task automatic random_stream(input int ch, input int n);
    logic [27:0]  a;
    logic [127:0] wd;
    int           kind;
    for (int i = 0; i < n; i++) begin
      a    = {23'($urandom_range(0, 3)), 5'($urandom_range(8, 11))};
      wd   = {$urandom, $urandom, $urandom, $urandom};
      kind = $urandom_range(0, 3);
      txn(ch, kind != 2, kind >= 2, a, wd, $urandom_range(1, 4));
    end
  endtask

  task automatic test_back_to_back_random();
    fork
      random_stream(0, 60);
      random_stream(1, 60);
    join
  endtask

  initial begin
    test_reset();
    test_read_miss_hit();
    test_write_evict();
    test_concurrent();
    test_reset_mid_alloc();
    test_rw_both();
    test_saturation();
    test_back_to_back_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
